// File: rtl/seg_scan_display_if.sv
// Bus between a value producer (e.g. the Cal block) and the seven-segment scanner.
// The scanner takes the slave modport; the producer/bench takes master.
interface seg_scan_display_if #(
  parameter int BITWIDTH = 8
);
  logic [BITWIDTH-1:0] value_in;
  logic                load;
  logic [7:0]          SEG;
  logic [7:0]          AN;

  modport master (output value_in, output load, input SEG, input AN);
  modport slave  (input value_in, input load, output SEG, output AN);
endinterface

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit hex scanner for an active-low seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_display #(
  parameter int BITWIDTH = 8,
  parameter int SCAN_DIV = 100000
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_display_if.slave bus
);

  localparam int NUM_DIG = (BITWIDTH + 3) / 4;
  localparam int DW      = 4 * NUM_DIG;
  localparam int CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_MAX = 3'(NUM_DIG - 1);

  logic [DW-1:0] disp_q;
  logic [DW-1:0] disp_ext;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    nib;
`ifdef SEG_LZ_BLANK_EN
  logic          zero_run;
  logic          blank;
`endif

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    disp_ext = '0;
    disp_ext[BITWIDTH-1:0] = bus.value_in;
  end

  // Walk from the top digit down so zero_run tells whether everything above is zero.
  always_comb begin
    nib = 4'h0;
`ifdef SEG_LZ_BLANK_EN
    zero_run = 1'b1;
    blank    = 1'b0;
`endif
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
`ifdef SEG_LZ_BLANK_EN
      zero_run = zero_run & (disp_q[4*i +: 4] == 4'h0);
`endif
      if (idx_q == 3'(i)) begin
        nib = disp_q[4*i +: 4];
`ifdef SEG_LZ_BLANK_EN
        blank = zero_run && (i != 0);
`endif
      end
    end
  end

  always_comb begin
    an_d  = ~(8'b1 << idx_q);
    seg_d = hex_to_seg(nib);
`ifdef SEG_LZ_BLANK_EN
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      seg_q  <= 8'hFF;
      an_q   <= 8'hFF;
    end else begin
      if (bus.load) begin
        disp_q <= disp_ext;
      end
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.SEG = seg_q;
  assign bus.AN  = an_q;

endmodule
